prio_encoder_rr: RTL and testbench
==================================

// Module: prio_encoder_rr
//
// PURPOSE
//   Parametrised N-input priority encoder with a registered output and a
//   valid/ready output handshake. It turns a request vector into the binary
//   index of the winning request. Two modes: fixed priority, where the highest
//   index wins, and round-robin, where the winner rotates. It sits between
//   request sources (interrupt lines, channel requests) and a downstream
//   consumer that can apply backpressure.
//
// PARAMETERS
//   N      8   number of request inputs, N >= 2
//   MODE   0   0 = fixed priority (highest index wins); 1 = round-robin
//   W      $clog2(N)   localparam, width of out_idx
//
// PORTS
//   clk        in   1    clock; all state changes on the rising edge
//   rst        in   1    synchronous, active-high reset
//   en         in   1    encoder enable; 0 blocks new captures
//   req        in   N    request vector; bit k = request from source k
//   out_ready  in   1    downstream accepts out_idx this cycle
//   out_valid  out  1    out_idx holds a valid winner
//   out_idx    out  W    binary index of the winning request
//
// BEHAVIOUR
//   Reset (rst=1 at the clock edge):
//   - out_valid <= 0, out_idx <= 0, rr_ptr <= N-1.
//   - rst has priority over every other input, including mid-handshake.
//   - A held (unaccepted) result is dropped on reset.
//   Capture condition:
//   - cap = en & |req & (!out_valid | out_ready).
//   - On cap: out_idx <= winner(req) and out_valid <= 1, visible the next cycle.
//   - Latency is 1 cycle from req to out_valid.
//   Drain and hold:
//   - If out_valid & out_ready & !cap: out_valid <= 0 and out_idx holds its value.
//   - If out_valid & !out_ready: out_valid and out_idx hold. req is ignored
//     while stalled and is not queued.
//   - Throughput: one grant per cycle while out_ready=1 and requests persist.
//   - en=0 does not affect an already-held result; it still drains on out_ready.
//   Winner, MODE=0:
//   - Highest set index of req. rr_ptr is unused.
//   Winner, MODE=1:
//   - Search downward from rr_ptr, wrapping from 0 to N-1, and take the first
//     set bit.
//   - On cap with winner k: rr_ptr <= (k==0) ? N-1 : k-1. Source k then has
//     the lowest priority on the next search.
//   - rr_ptr changes only on cap.
//   - Right after reset, MODE=1 behaves like MODE=0 for the first grant.
//   Boundaries:
//   - req=0 with en=1: no capture, so out_valid falls if it was accepted.
//   - A single request always wins, whatever rr_ptr is.
//   - Simultaneous accept and capture gives a seamless back-to-back result,
//     with out_valid staying 1.
//   - N not a power of 2: out_idx never exceeds N-1.
//   - Pointer wrap: from k=0, rr_ptr goes to N-1.
//   - No combinational path from req to any output.
//
// TESTING
//   1 MODE=0 N=8: req=8'b1010_0000, en=1, out_ready=1
//     -> next cycle out_valid=1, out_idx=7.
//   2 MODE=1 N=8: req=8'hFF held, out_ready=1
//     -> out_idx sequence 7,6,5,4,3,2,1,0,7, one per cycle, out_valid constant 1.
//   3 Backpressure: result idx=7 valid, out_ready=0 for 3 cycles, req changed
//     to 8'h04 -> out_idx stays 7. On out_ready=1 -> next out_idx=2.
//   4 en=0, req=8'h01 for 4 cycles -> out_valid stays 0.
//     Raise en -> next cycle out_idx=0, out_valid=1.
//   5 MODE=1: grant idx 5, then assert rst for 1 cycle -> out_valid=0, out_idx=0.
//     Then req=8'hFF -> first out_idx=7.
//   6 N=5, MODE=1: req=5'b1_0001
//     -> out_idx 4,0,4,0. Check out_idx never exceeds 4.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// N-input priority encoder with a registered winner index and a valid/ready output.
// MODE=0 grants the highest set index; MODE=1 rotates the grant downward from rr_ptr.
module prio_encoder_rr #(
   parameter  int N    = 8,
   parameter  int MODE = 0,
   localparam int W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx
);

   logic         valid_q, valid_d;
   logic [W-1:0] idx_q, idx_d;
   logic [W-1:0] rr_ptr_q, rr_ptr_d;

   logic [W-1:0] win_hi;
   logic [W-1:0] win_lo;
   logic         found_lo;
   logic [W-1:0] winner;
   logic         cap;

   // win_hi is the highest set bit overall; win_lo is the highest set bit at or
   // below rr_ptr, which is the first hit of a downward search before it wraps.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      win_hi   = '0;
      win_lo   = '0;
      found_lo = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            win_hi = W'(i);
            if (i <= int'(rr_ptr_q)) begin
               win_lo   = W'(i);
               found_lo = 1'b1;
            end
         end
      end
      winner = (MODE == 1 && found_lo) ? win_lo : win_hi;
   end

   assign cap = en & (|req) & (~valid_q | out_ready);

   always_comb begin
      valid_d  = valid_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      if (cap) begin
         valid_d  = 1'b1;
         idx_d    = winner;
         rr_ptr_d = (winner == '0) ? W'(N - 1) : winner - W'(1);
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         idx_q    <= '0;
         rr_ptr_q <= W'(N - 1);
      end else begin
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_idx   = idx_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed N=8, round-robin N=8 and round-robin N=5 instances
// checked against a grant model built from "last winner" rotation.
module tb_prio_encoder_rr;

   logic       clk = 1'b0;
   logic       rst, en, out_ready;
   logic [7:0] req8;
   logic [4:0] req5;

   logic       v_fx, v_rr, v_r5;
   logic [2:0] i_fx, i_rr, i_r5;

   int vectors     = 0;
   int miscompares = 0;

   // model state per instance: 0 = fixed N=8, 1 = rr N=8, 2 = rr N=5
   int m_v[3];
   int m_i[3];
   int m_last[3];
   int n_of[3]    = '{8, 8, 5};
   int mode_of[3] = '{0, 1, 1};

   always #5 clk = ~clk;

   prio_encoder_rr #(.N(8), .MODE(0)) u_fx (
      .clk(clk), .rst(rst), .en(en), .req(req8), .out_ready(out_ready),
      .out_valid(v_fx), .out_idx(i_fx));

   prio_encoder_rr #(.N(8), .MODE(1)) u_rr (
      .clk(clk), .rst(rst), .en(en), .req(req8), .out_ready(out_ready),
      .out_valid(v_rr), .out_idx(i_rr));

   prio_encoder_rr #(.N(5), .MODE(1)) u_r5 (
      .clk(clk), .rst(rst), .en(en), .req(req5), .out_ready(out_ready),
      .out_valid(v_r5), .out_idx(i_r5));

   // Fixed: highest set index. Round-robin: walk down from the source just below
   // the last winner, modulo n; "last = n" before any grant makes n-1 come first.
   function automatic int pick(int n, int mode, logic [7:0] r, int last);
      if (mode == 0) begin
         for (int k = n - 1; k >= 0; k--)
            if (r[k]) return k;
      end else begin
         for (int off = 1; off <= n; off++) begin
            int k;
            k = ((last - off) % n + n) % n;
            if (r[k]) return k;
         end
      end
      return 0;
   endfunction

   task automatic model_update();
      logic [7:0] r;
      for (int u = 0; u < 3; u++) begin
         r = (u == 2) ? {3'b000, req5} : req8;
         if (rst) begin
            m_v[u]    = 0;
            m_i[u]    = 0;
            m_last[u] = n_of[u];
         end else if (en && r != 8'h00 && (m_v[u] == 0 || out_ready)) begin
            m_i[u]    = pick(n_of[u], mode_of[u], r, m_last[u]);
            m_v[u]    = 1;
            m_last[u] = m_i[u];
         end else if (m_v[u] == 1 && out_ready) begin
            m_v[u] = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock: model consumes the inputs seen at the edge, then all
   // outputs are compared 1 time unit after the edge.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check("fx_valid", v_fx, m_v[0]);
      check("fx_idx",   i_fx, m_i[0]);
      check("rr_valid", v_rr, m_v[1]);
      check("rr_idx",   i_rr, m_i[1]);
      check("r5_valid", v_r5, m_v[2]);
      check("r5_idx",   i_r5, m_i[2]);
      check("r5_idx_range", (i_r5 <= 3'd4), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; out_ready = 1'b0; req8 = '0; req5 = '0;
      step();
      step();
      check("reset_valid", v_fx, 0);
      check("reset_idx", i_rr, 0);
      rst = 1'b0;

      // fixed priority picks bit 7 out of 1010_0000
      en = 1'b1; out_ready = 1'b1; req8 = 8'b1010_0000;
      step();
      check("t1_valid", v_fx, 1);
      check("t1_idx", i_fx, 7);

      // round-robin sweep with all requests held
      do_reset();
      req8 = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         step();
         check("t2_idx", i_rr, (i == 8) ? 7 : 7 - i);
         check("t2_valid", v_rr, 1);
      end

      // backpressure: held result ignores new req until accepted
      do_reset();
      req8 = 8'hFF;
      step();
      check("t3_first", i_fx, 7);
      out_ready = 1'b0; req8 = 8'h04;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_hold_idx", i_fx, 7);
         check("t3_hold_valid", v_fx, 1);
      end
      out_ready = 1'b1;
      step();
      check("t3_next", i_fx, 2);

      // zero request while accepted drops valid and holds the index
      req8 = 8'h00;
      step();
      check("drain_valid", v_fx, 0);
      check("drain_idx", i_fx, 2);

      // enable gating
      do_reset();
      en = 1'b0; req8 = 8'h01;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_blocked", v_fx, 0);
      end
      en = 1'b1;
      step();
      check("t4_valid", v_fx, 1);
      check("t4_idx", i_fx, 0);

      // reset mid-sequence restores the initial pointer
      do_reset();
      req8 = 8'h20;
      step();
      check("t5_grant", i_rr, 5);
      rst = 1'b1;
      step();
      check("t5_rst_valid", v_rr, 0);
      check("t5_rst_idx", i_rr, 0);
      rst = 1'b0; req8 = 8'hFF;
      step();
      check("t5_after", i_rr, 7);

      // N=5 alternation between sources 4 and 0
      do_reset();
      req8 = 8'h00; req5 = 5'b1_0001;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t6_idx", i_r5, (i % 2 == 0) ? 4 : 0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 49) == 0);
         en        = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         req8      = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         req5      = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
